obi_mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one single-ported SRAM between the core instruction and data OBI interfaces, bypassing the AXI crossbar for tightly-coupled memory. It grants at most one request per cycle and drives the memory port. It returns `rvalid`/`rdata` to the originating port after the SRAM's fixed read latency, for both reads and writes. Per-port saturating grant counters feed performance monitoring.

---
 rtl/obi_arb_pkg.sv | 19 +
 rtl/rr_arb_2.sv | 49 ++++
 rtl/obi_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_obi_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_arb_pkg.sv
// Shared definitions for the OBI memory arbiter.
//   port_idx_t    : requester index (0 = instruction, 1 = data)
//   PORT_INSTR/PORT_DATA : named requester indices
//   MAX_LATENCY   : deepest supported SRAM read latency
//   resp_stage_t  : one response-pipeline stage {valid, port}
package obi_arb_pkg;

  typedef logic port_idx_t;

  localparam port_idx_t PORT_INSTR  = 1'b0;
  localparam port_idx_t PORT_DATA   = 1'b1;
  localparam int        MAX_LATENCY = 4;

  typedef struct packed {
    logic      valid;
    port_idx_t port;
  } resp_stage_t;

endpackage

// File: rtl/rr_arb_2.sv
// Two-requester round-robin arbiter.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i[1:0]   : request per port
//   advance_i    : a grant is being committed this cycle; move the pointer
//   gnt_o[1:0]   : one-hot grant (zero when nothing requests), combinational
//   idx_o        : granted port index; PORT_INSTR when nothing requests
// The last_q pointer remembers the most recently granted port; under
// contention the other port wins. Reset value PORT_DATA makes port 0 win
// the first contention.
module rr_arb_2
  import obi_arb_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic [1:0] req_i,
  input  logic      advance_i,
  output logic [1:0] gnt_o,
  output port_idx_t idx_o
);

  port_idx_t last_q;
  port_idx_t last_d;

  always_comb begin
    idx_o = PORT_INSTR;
    if (req_i == 2'b11) begin
      idx_o = ~last_q;
    end else if (req_i[1]) begin
      idx_o = PORT_DATA;
    end
    gnt_o = (req_i == 2'b00) ? 2'b00 : (2'b01 << idx_o);
  end

  always_comb begin
    last_d = last_q;
    if (advance_i) begin
      last_d = idx_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= PORT_DATA;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported SRAM between the
// instruction (port 0) and data (port 1) OBI interfaces.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   p_req_i/p_gnt_o   : per-port request / combinational grant
//   p_addr_i, p_we_i, p_be_i, p_wdata_i : per-port request fields
//   p_rvalid_o        : per-port response valid, LATENCY cycles after grant
//   p_rdata_o         : response data shared by both ports
//   mem_*_o           : SRAM request port (memory is always ready)
//   mem_rdata_i       : SRAM read data, LATENCY cycles after mem_req_o
//   cnt_clr_i         : synchronous clear of the grant counters
//   gnt_cnt_o         : saturating grant counters per port
// Handshake: a request is committed only in a cycle where p_req_i and
// p_gnt_o are both high at the rising edge; that transaction then gets
// exactly one p_rvalid_o pulse (reads and writes alike), in grant order.
module obi_mem_arbiter
  import obi_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             p_req_i,
  output logic [1:0]             p_gnt_o,
  input  logic [1:0][ADDR_W-1:0] p_addr_i,
  input  logic [1:0]             p_we_i,
  input  logic [1:0][DATA_W/8-1:0] p_be_i,
  input  logic [1:0][DATA_W-1:0] p_wdata_i,
  output logic [1:0]             p_rvalid_o,
  output logic [DATA_W-1:0]      p_rdata_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [DATA_W/8-1:0]    mem_be_o,
  output logic [DATA_W-1:0]      mem_wdata_o,
  input  logic [DATA_W-1:0]      mem_rdata_i,
  input  logic                   cnt_clr_i,
  output logic [1:0][CNT_W-1:0]  gnt_cnt_o
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("obi_mem_arbiter: LATENCY must be in 1..4");
  end

  logic      any_req;
  port_idx_t gnt_idx;

  assign any_req = |p_req_i;

  rr_arb_2 u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (p_req_i),
    .advance_i (any_req),
    .gnt_o     (p_gnt_o),
    .idx_o     (gnt_idx)
  );

  // gnt_idx is PORT_INSTR when idle, so the idle memory fields come from
  // port 0 and never float.
  assign mem_req_o   = any_req;
  assign mem_we_o    = p_we_i[gnt_idx];
  assign mem_addr_o  = p_addr_i[gnt_idx];
  assign mem_be_o    = p_be_i[gnt_idx];
  assign mem_wdata_o = p_wdata_i[gnt_idx];

  // Response pipeline: tracks which port owns the word arriving on
  // mem_rdata_i at the final stage.
  resp_stage_t pipe_q [LATENCY];
  resp_stage_t pipe_d [LATENCY];

  always_comb begin
    pipe_d[0].valid = any_req;
    pipe_d[0].port  = gnt_idx;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  always_comb begin
    p_rvalid_o = 2'b00;
    p_rvalid_o[pipe_q[LATENCY-1].port] = pipe_q[LATENCY-1].valid;
  end

  assign p_rdata_o = mem_rdata_i;

  // Saturating grant counters; a clear wins over a same-cycle grant.
  logic [1:0][CNT_W-1:0] cnt_q;
  logic [1:0][CNT_W-1:0] cnt_d;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr_i) begin
        cnt_d[i] = '0;
      end else if (p_gnt_o[i] && !(&cnt_q[i])) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign gnt_cnt_o = cnt_q;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
module tb_obi_mem_arbiter;

  localparam int LAT   = 3;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int SB_W  = 66; // {due[31:0], we, port, data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        p_req = '0;
  logic [1:0]        p_gnt;
  logic [1:0][31:0]  p_addr = '0;
  logic [1:0]        p_we = '0;
  logic [1:0][3:0]   p_be = '0;
  logic [1:0][31:0]  p_wdata = '0;
  logic [1:0]        p_rvalid;
  logic [31:0]       p_rdata;
  logic              mem_req, mem_we;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  logic [3:0]        mem_be;
  logic              cnt_clr = 1'b0;
  logic [1:0][CNT_W-1:0] gnt_cnt;

  obi_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .p_req_i(p_req), .p_gnt_o(p_gnt), .p_addr_i(p_addr), .p_we_i(p_we),
    .p_be_i(p_be), .p_wdata_i(p_wdata), .p_rvalid_o(p_rvalid), .p_rdata_o(p_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .cnt_clr_i(cnt_clr), .gnt_cnt_o(gnt_cnt)
  );

  // ---------------- behavioural SRAM (16 words) ----------------
  logic [31:0] sram [16];
  logic [31:0] rd_pipe [LAT];
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (mem_req && !rst) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      rd_pipe[0] <= sram[mem_addr[5:2]];
    end
    for (int s = 1; s < LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0]     model_mem [16];
  logic            model_last;
  int              model_cnt [2];
  int              cyc = 0;
  logic [SB_W-1:0] exp_q [$];
  int              n_chk = 0;
  int              n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    model_last   = 1'b1;
    model_cnt[0] = 0;
    model_cnt[1] = 0;
  endtask

  // Called just after a negedge with inputs driven; checks, updates the
  // model, and returns at the next negedge.
  task automatic do_cycle();
    logic [1:0]      eg;
    logic            widx;
    logic [SB_W-1:0] e;
    logic [3:0]      w;
    #1;
    eg = 2'b00;
    widx = 1'b0;
    if (p_req == 2'b11) widx = ~model_last;
    else if (p_req[1]) widx = 1'b1;
    if (p_req != 2'b00) eg = 2'b01 << widx;
    chk("gnt", 64'(p_gnt), 64'(eg));
    chk("mem_req", 64'(mem_req), 64'(p_req != 2'b00));
    if (p_req != 2'b00) begin
      chk("mem_addr", 64'(mem_addr), 64'(p_addr[widx]));
      chk("mem_we", 64'(mem_we), 64'(p_we[widx]));
      if (p_we[widx]) begin
        chk("mem_be", 64'(mem_be), 64'(p_be[widx]));
        chk("mem_wdata", 64'(mem_wdata), 64'(p_wdata[widx]));
      end
    end
    if (exp_q.size() != 0 && exp_q[0][65:34] == 32'(cyc)) begin
      e = exp_q.pop_front();
      chk("rvalid", 64'(p_rvalid), 64'(2'b01 << e[32]));
      if (!e[33]) chk("rdata", 64'(p_rdata), 64'(e[31:0]));
    end else begin
      chk("rvalid_idle", 64'(p_rvalid), 64'(0));
    end
    chk("cnt0", 64'(gnt_cnt[0]), 64'(model_cnt[0]));
    chk("cnt1", 64'(gnt_cnt[1]), 64'(model_cnt[1]));
    if (p_req != 2'b00) begin
      w = p_addr[widx][5:2];
      exp_q.push_back({32'(cyc + LAT), p_we[widx], widx, model_mem[w]});
      if (p_we[widx])
        for (int b = 0; b < 4; b++)
          if (p_be[widx][b]) model_mem[w][8*b +: 8] = p_wdata[widx][8*b +: 8];
      model_last = widx;
    end
    for (int i = 0; i < 2; i++) begin
      if (cnt_clr) model_cnt[i] = 0;
      else if (eg[i] && model_cnt[i] < CMAX) model_cnt[i]++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p_req = 2'b00;
    cnt_clr = 1'b0;
    #1;
    chk("rst_rvalid", 64'(p_rvalid), 64'(0));
    chk("rst_cnt0", 64'(gnt_cnt[0]), 64'(0));
    chk("rst_cnt1", 64'(gnt_cnt[1]), 64'(0));
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    p_req = 2'b00;
    for (int i = 0; i < n; i++) do_cycle();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] req;
    logic [1:0] we;
    logic [1:0] exp_gnt;
  } vec_t;
  vec_t tbl [10];

  initial begin
    tbl[0] = '{2'b01, 2'b00, 2'b01};
    tbl[1] = '{2'b11, 2'b00, 2'b10};
    tbl[2] = '{2'b11, 2'b00, 2'b01};
    tbl[3] = '{2'b11, 2'b00, 2'b10};
    tbl[4] = '{2'b10, 2'b10, 2'b10};
    tbl[5] = '{2'b11, 2'b00, 2'b01};
    tbl[6] = '{2'b00, 2'b00, 2'b00};
    tbl[7] = '{2'b11, 2'b00, 2'b10};
    tbl[8] = '{2'b01, 2'b01, 2'b01};
    tbl[9] = '{2'b10, 2'b00, 2'b10};

    // Words 0..3 stay zero; 4..15 get random contents.
    for (int i = 0; i < 16; i++) begin
      sram[i] = (i < 4) ? 32'h0 : $urandom;
      model_mem[i] = sram[i];
    end
    for (int s = 0; s < LAT; s++) rd_pipe[s] = '0;
    model_reset();

    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Table phase: starts with port 0 alone reading 0x80000010.
    for (int i = 0; i < 10; i++) begin
      p_req      = tbl[i].req;
      p_we       = tbl[i].we;
      p_addr[0]  = 32'h8000_0010 + 32'((i % 4) << 2);
      p_addr[1]  = 32'h8000_0010 + 32'(((i + 1) % 4) << 2);
      p_be[0]    = 4'hF;
      p_be[1]    = 4'hF;
      p_wdata[0] = $urandom;
      p_wdata[1] = $urandom;
      #1 chk("tbl_gnt", 64'(p_gnt), 64'(tbl[i].exp_gnt));
      do_cycle();
    end
    p_we = 2'b00;
    idle(LAT + 1);

    // Both ports continuously for 6 cycles right after reset: 0,1,0,1,0,1.
    do_reset();
    p_addr[0] = 32'h8000_0020;
    p_addr[1] = 32'h8000_0024;
    for (int i = 0; i < 6; i++) begin
      p_req = 2'b11;
      #1 chk("alt_gnt", 64'(p_gnt), 64'(2'b01 << (i % 2)));
      do_cycle();
    end
    idle(LAT + 1);
    chk("alt_cnt0", 64'(gnt_cnt[0]), 64'(3));
    chk("alt_cnt1", 64'(gnt_cnt[1]), 64'(3));

    // Partial write then read of a zero word: read returns 0x0000BEEF.
    p_req = 2'b10; p_we = 2'b10; p_addr[1] = 32'h8000_0040;
    p_wdata[1] = 32'hDEAD_BEEF; p_be[1] = 4'b0011;
    do_cycle();
    p_req = 2'b01; p_we = 2'b00; p_addr[0] = 32'h8000_0040;
    do_cycle();
    p_req = 2'b00;
    for (int i = 0; i < LAT; i++) begin
      if (i == LAT - 2) chk("wr_rvalid", 64'(p_rvalid), 64'(2'b10));
      if (i == LAT - 1) begin
        chk("rd_rvalid", 64'(p_rvalid), 64'(2'b01));
        chk("rd_beef", 64'(p_rdata), 64'(32'h0000_BEEF));
      end
      do_cycle();
    end

    // Reset one cycle after a grant: the response must never appear.
    p_req = 2'b01; p_addr[0] = 32'h8000_0030;
    do_cycle();
    do_reset();
    idle(LAT + 2);

    // Counter saturation and clear priority.
    p_req = 2'b01;
    for (int i = 0; i < 20; i++) do_cycle();
    chk("sat_cnt0", 64'(gnt_cnt[0]), 64'(CMAX));
    cnt_clr = 1'b1;
    do_cycle();
    cnt_clr = 1'b0;
    chk("clr_cnt0", 64'(gnt_cnt[0]), 64'(0));
    idle(LAT + 1);

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      p_req = 2'($urandom_range(0, 3));
      p_we = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        p_addr[p]  = 32'h8000_0000 | 32'($urandom_range(0, 15) << 2);
        p_be[p]    = 4'($urandom_range(0, 15));
        p_wdata[p] = $urandom;
      end
      cnt_clr = ($urandom_range(0, 31) == 0);
      do_cycle();
    end
    cnt_clr = 1'b0;

    // Drain with a bounded wait.
    p_req = 2'b00;
    for (int i = 0; i < LAT + 2 && exp_q.size() != 0; i++) do_cycle();
    chk("drain", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
